// File: rtl/adc_playback_pkg.sv
// Shared constants, FSM encoding and the 96->128 sample packing helper for adc_playback_source.
// ADC_PLAYBACK_SYNC_EN adds the ARMED state used when playback waits for an external update strobe.
package adc_playback_pkg;

  localparam int SAMPLE_BITS      = 12;
  localparam int SAMPLES_PER_BEAT = 8;
  localparam int LANE_BITS        = 16;
  localparam int BEAT_BITS        = SAMPLE_BITS * SAMPLES_PER_BEAT;
  localparam int AXIS_BITS        = LANE_BITS * SAMPLES_PER_BEAT;

  localparam logic [19:0] REG_CTRL   = 20'h00000;
  localparam logic [19:0] REG_LENGTH = 20'h00004;
  localparam logic [19:0] REG_STATUS = 20'h00008;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM,
`ifdef ADC_PLAYBACK_SYNC_EN
    ST_ARMED,
`endif
    ST_DONE
  } state_t;

  // Each 12-bit sample sits left-justified in a 16-bit lane; sample 0 is the oldest.
  function automatic logic [AXIS_BITS-1:0] pack_beat(input logic [BEAT_BITS-1:0] beat);
    logic [AXIS_BITS-1:0] out_beat;
    out_beat = '0;
    for (int i = 0; i < SAMPLES_PER_BEAT; i++) begin
      out_beat[LANE_BITS*i + (LANE_BITS-SAMPLE_BITS) +: SAMPLE_BITS] = beat[SAMPLE_BITS*i +: SAMPLE_BITS];
    end
    return out_beat;
  endfunction

endpackage

// File: rtl/adc_playback_ram.sv
// Beat store for adc_playback_source: one 96-bit read port, four 24-bit sample-pair write lanes.
// Read data is registered and only advances when rd_en is high, so it doubles as the output holding register.
module adc_playback_ram
  import adc_playback_pkg::*;
#(
  parameter int DEPTH_BITS = 9
) (
  input  logic                  clk,
  input  logic [3:0]            wr_en,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [23:0]           wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_BITS-1:0] rd_addr,
  output logic [BEAT_BITS-1:0]  rd_data
);

  logic [BEAT_BITS-1:0] mem [2**DEPTH_BITS];

  // NOTE: neither the array nor rd_data is reset, which keeps this mappable onto block RAM;
  // the top masks m_tdata by state so the unreset read register never leaks out.
  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) mem[wr_addr][24*k +: 24] <= wr_data;
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_playback_source.sv
// Wishbone-loadable beat RAM replayed once or looped as a 128-bit ADC-format AXI4-Stream.
// Define ADC_PLAYBACK_SYNC_EN to add update_i: a started run then waits ARMED until update_i is seen high.
module adc_playback_source
  import adc_playback_pkg::*;
#(
  parameter int DEPTH_BITS    = 9,
  parameter int LOOP_CNT_BITS = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [21:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o,
  output logic [AXIS_BITS-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready
`ifdef ADC_PLAYBACK_SYNC_EN
  , input logic                update_i
`endif
);

`ifdef ADC_PLAYBACK_SYNC_EN
  localparam state_t START_STATE = ST_ARMED;
`else
  localparam state_t START_STATE = ST_FETCH;
`endif

  state_t                   state_q, state_d;
  logic                     run_q, loop_en_q;
  logic [DEPTH_BITS-1:0]    length_q;
  logic [DEPTH_BITS-1:0]    ptr_q, ptr_d;
  logic                     done_q, done_d;
  logic [LOOP_CNT_BITS-1:0] loop_cnt_q, loop_cnt_d;
  logic                     rd_en;
  logic [BEAT_BITS-1:0]     rd_data;
  logic                     wb_req, reg_we, ram_we, ctrl_we, length_we, run_rise;
  logic                     wrap, running, armed;
  logic [3:0]               ram_lane_we;
  logic [31:0]              reg_rdata;
  logic                     unused_bits;

  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign unused_bits = ^{wb_adr_i[21], wb_dat_i[31:28], wb_dat_i[15:12]};

  // A request is only taken while ack is low, so every access gets exactly one ack pulse.
  assign wb_req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign reg_we      = wb_req & wb_we_i & (wb_sel_i == 4'hF);
  assign ram_we      = reg_we & wb_adr_i[20];
  assign ctrl_we     = reg_we & ~wb_adr_i[20] & (wb_adr_i[19:0] == REG_CTRL);
  assign length_we   = reg_we & ~wb_adr_i[20] & (wb_adr_i[19:0] == REG_LENGTH);
  assign run_rise    = ctrl_we & wb_dat_i[0] & ~run_q;
  assign ram_lane_we = ram_we ? (4'b0001 << wb_adr_i[3:2]) : 4'b0000;

  assign running = (state_q == ST_FETCH) || (state_q == ST_STREAM);
`ifdef ADC_PLAYBACK_SYNC_EN
  assign armed = (state_q == ST_ARMED);
`else
  assign armed = 1'b0;
`endif

  always_comb begin
    reg_rdata = '0;
    if (!wb_adr_i[20]) begin
      case (wb_adr_i[19:0])
        REG_CTRL:   reg_rdata[1:0] = {loop_en_q, run_q};
        REG_LENGTH: reg_rdata[DEPTH_BITS-1:0] = length_q;
        REG_STATUS: reg_rdata = {16'(loop_cnt_q), 13'b0, armed, done_q, running};
        default:    reg_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      run_q     <= 1'b0;
      loop_en_q <= 1'b0;
      length_q  <= '0;
    end else begin
      wb_ack_o <= wb_req;
      wb_dat_o <= (wb_req && !wb_we_i) ? reg_rdata : '0;
      if (ctrl_we) begin
        run_q     <= wb_dat_i[0];
        loop_en_q <= wb_dat_i[1];
      end
      if (length_we) length_q <= wb_dat_i[DEPTH_BITS-1:0];
    end
  end

  assign wrap = (ptr_q == length_q);

  // NOTE: every signal written here is given a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    done_d     = done_q;
    loop_cnt_d = loop_cnt_q;
    rd_en      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (run_rise) begin
          done_d     = 1'b0;
          loop_cnt_d = '0;
          ptr_d      = '0;
          state_d    = START_STATE;
        end else if (state_q == ST_DONE && !run_q) begin
          state_d = ST_IDLE;
        end
      end
`ifdef ADC_PLAYBACK_SYNC_EN
      ST_ARMED: begin
        if (!run_q)        state_d = ST_IDLE;
        else if (update_i) state_d = ST_FETCH;
      end
`endif
      ST_FETCH: begin
        rd_en   = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // The next beat is fetched on the handshake itself, keeping one beat per cycle.
        if (m_tready) begin
          if (!run_q) begin
            state_d = ST_IDLE;
          end else if (wrap && !loop_en_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            rd_en = 1'b1;
            ptr_d = wrap ? '0 : ptr_q + 1'b1;
            if (wrap && loop_cnt_q != '1) loop_cnt_d = loop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      done_q     <= 1'b0;
      loop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      done_q     <= done_d;
      loop_cnt_q <= loop_cnt_d;
    end
  end

  adc_playback_ram #(
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (ram_lane_we),
    .wr_addr (wb_adr_i[DEPTH_BITS+3:4]),
    .wr_data ({wb_dat_i[27:16], wb_dat_i[11:0]}),
    .rd_en   (rd_en),
    .rd_addr (ptr_d),
    .rd_data (rd_data)
  );

  assign m_tvalid = (state_q == ST_STREAM);
  assign m_tdata  = m_tvalid ? pack_beat(rd_data) : '0;

endmodule

// File: tb/tb_adc_playback_source.sv
// Self-checking bench for adc_playback_source: directed steps with a scoreboard queue of expected beats.
// Build with ADC_PLAYBACK_SYNC_EN defined to also exercise the armed start.
module tb_adc_playback_source;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         cyc, stb, we;
  logic [21:0]  adr;
  logic [31:0]  dat_w, dat_r;
  logic [3:0]   sel;
  logic         ack, err, rty;
  logic [127:0] tdata;
  logic         tvalid, tready;
`ifdef ADC_PLAYBACK_SYNC_EN
  logic         update;
`endif

  int           n_cmp = 0;
  int           n_err = 0;
  int           step_no = 0;
  int           hs_count, first_hs, last_hs;
  logic [127:0] held;
  bit           held_v = 1'b0;
  logic [127:0] exp_q[$];
  logic [11:0]  smp [0:31];
  logic [31:0]  rd;

  always #5 aclk = ~aclk;

  adc_playback_source dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (dat_w),
    .wb_sel_i (sel),
    .wb_dat_o (dat_r),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty),
    .m_tdata  (tdata),
    .m_tvalid (tvalid),
    .m_tready (tready)
`ifdef ADC_PLAYBACK_SYNC_EN
    , .update_i (update)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_beat(input int b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[16*i+4 +: 12] = smp[b*8+i];
    return r;
  endfunction

  // Observes the stream at the falling edge; a handshake here happens on the next rising edge.
  task automatic monitor();
    if (tvalid) begin
      if (held_v) check("stall_stable", tdata, held);
      if (tready) begin
        check("beat_pending", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) check("beat_data", tdata, exp_q.pop_front());
        if (hs_count == 0) first_hs = step_no;
        last_hs = step_no;
        hs_count++;
        held_v = 1'b0;
      end else begin
        held   = tdata;
        held_v = 1'b1;
      end
    end else begin
      if (held_v) check("valid_held", 128'(tvalid), 128'(1));
      held_v = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
    step_no++;
  endtask

  task automatic wb_xfer(input logic w, input logic [21:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] q);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    n = 0;
    do begin
      step();
      n++;
    end while (!ack && n < 8);
    check("wb_ack", 128'(ack), 128'(1));
    q   = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [21:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic wb_read(input logic [21:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, 32'h0, 4'hF, q);
  endtask

  task automatic load_beat(input int b);
    for (int k = 0; k < 4; k++) begin
      wb_write(22'h10_0000 | 22'(b*16 + k*4), {4'h0, smp[b*8+2*k+1], 4'h0, smp[b*8+2*k]});
    end
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      step();
      n++;
    end
    check(tag, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic run_until(input string tag, input int target, input int bound, input bit rnd);
    int n;
    n = 0;
    while (hs_count < target && n < bound) begin
      if (rnd) tready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    tready = 1'b0;
    check(tag, 128'(hs_count), 128'(target));
  endtask

  // Stalls, clears RUN under the stall, then lets the pending beat go.
  task automatic stop_run(input string tag);
    repeat (5) step();
    wb_write(22'h0, 32'h0);
    tready = 1'b1;
    drain({tag, "_drain"}, 10);
    repeat (5) step();
    check({tag, "_idle_valid"}, 128'(tvalid), 128'(0));
    wb_read(22'h8, rd);
    check({tag, "_idle_status"}, 128'(rd[1:0]), 128'(0));
  endtask

  initial begin
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = 4'hF; tready = 1'b0;
`ifdef ADC_PLAYBACK_SYNC_EN
    update = 1'b0;
`endif
    aresetn = 1'b0;
    repeat (3) step();
    aresetn = 1'b1;
    step();

    check("rst_tvalid", 128'(tvalid), 128'(0));
    check("rst_tdata", tdata, 128'(0));
    check("rst_ack", 128'(ack), 128'(0));
    check("rst_dat", 128'(dat_r), 128'(0));
    check("rst_err_rty", 128'({err, rty}), 128'(0));
    wb_read(22'h8, rd);
    check("rst_status", 128'(rd), 128'(0));

    wb_xfer(1'b1, 22'h4, 32'h5, 4'h3, rd);
    wb_read(22'h4, rd);
    check("partial_sel_ignored", 128'(rd), 128'(0));
    wb_read(22'hC, rd);
    check("unmapped_read", 128'(rd), 128'(0));

    // Single beat, LENGTH=0, no loop.
    for (int i = 0; i < 8; i++) smp[i] = 12'(i + 1);
    load_beat(0);
    wb_read(22'h10_0000, rd);
    check("ram_read_zero", 128'(rd), 128'(0));
    wb_write(22'h4, 32'h0);
    tready = 1'b1;
    exp_q.push_back(128'h0080_0070_0060_0050_0040_0030_0020_0010);
    hs_count = 0;
    wb_write(22'h0, 32'h1);
    drain("t1_drain", 20);
    repeat (3) step();
    check("t1_beats", 128'(hs_count), 128'(1));
    check("t1_tvalid_low", 128'(tvalid), 128'(0));
    wb_read(22'h8, rd);
    check("t1_status", 128'(rd), 128'(32'h2));
    wb_write(22'h0, 32'h0);

    // Four beats looped, continuous ready.
    for (int i = 0; i < 32; i++) smp[i] = 12'($urandom);
    for (int b = 0; b < 4; b++) load_beat(b);
    wb_write(22'h4, 32'h3);
    for (int i = 0; i < 20; i++) exp_q.push_back(exp_beat(i % 4));
    hs_count = 0;
    tready = 1'b1;
    wb_write(22'h0, 32'h3);
    run_until("t2_beats", 19, 60, 1'b0);
    check("t2_no_gaps", 128'(last_hs - first_hs), 128'(18));
    wb_read(22'h8, rd);
    check("t2_status", 128'(rd), 128'({16'(19 / 4), 16'h0001}));
    check("t2_stall_valid", 128'(tvalid), 128'(1));
    stop_run("t2");

    // Random ready stalls.
    for (int i = 0; i < 30; i++) exp_q.push_back(exp_beat(i % 4));
    hs_count = 0;
    wb_write(22'h0, 32'h3);
    run_until("t3_beats", 29, 400, 1'b1);
    stop_run("t3");

    // Reset mid-stream, then confirm the RAM survived.
    for (int i = 0; i < 5; i++) exp_q.push_back(exp_beat(i % 4));
    hs_count = 0;
    tready = 1'b1;
    wb_write(22'h0, 32'h3);
    run_until("t5_pre_beats", 5, 40, 1'b0);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    held_v = 1'b0;
    check("t5_rst_tvalid", 128'(tvalid), 128'(0));
    check("t5_rst_tdata", tdata, 128'(0));
    wb_read(22'h0, rd);
    check("t5_rst_ctrl", 128'(rd), 128'(0));
    wb_read(22'h4, rd);
    check("t5_rst_length", 128'(rd), 128'(0));
    wb_read(22'h8, rd);
    check("t5_rst_status", 128'(rd), 128'(0));
    wb_write(22'h4, 32'h3);
    for (int b = 0; b < 4; b++) exp_q.push_back(exp_beat(b));
    tready = 1'b1;
    wb_write(22'h0, 32'h1);
    drain("t5_replay_drain", 30);
    repeat (3) step();
    wb_read(22'h8, rd);
    check("t5_replay_status", 128'(rd), 128'(32'h2));

`ifdef ADC_PLAYBACK_SYNC_EN
    begin
      bit saw_valid;
      wb_write(22'h0, 32'h0);
      wb_write(22'h4, 32'h0);
      wb_write(22'h0, 32'h1);
      wb_read(22'h8, rd);
      check("sync_armed_status", 128'(rd), 128'(32'h4));
      saw_valid = 1'b0;
      repeat (8) begin
        step();
        saw_valid |= tvalid;
      end
      check("sync_wait_no_valid", 128'(saw_valid), 128'(0));
      exp_q.push_back(exp_beat(0));
      update = 1'b1;
      step();
      update = 1'b0;
      check("sync_valid_after_1", 128'(tvalid), 128'(0));
      step();
      check("sync_valid_after_2", 128'(tvalid), 128'(1));
      drain("sync_drain", 10);
      repeat (3) step();
      wb_read(22'h8, rd);
      check("sync_done_status", 128'(rd), 128'(32'h2));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
